// File: rtl/eth_tx_arbiter.sv
// Round-robin frame arbiter: moves whole frames from encoder A or B FIFO pairs
// into the shared MAC transmit FIFO pair, data words first and ctl word last.
module eth_tx_arbiter #(
  parameter int LEN_W     = 7,
  parameter int MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic        a_ctl_rd_en_out,
  input  logic [15:0] a_ctl_rd_d_in,
  input  logic        a_ctl_rd_empty_in,
  output logic        a_data_rd_en_out,
  input  logic [63:0] a_data_rd_d_in,
  input  logic        a_data_rd_empty_in,
  output logic        b_ctl_rd_en_out,
  input  logic [15:0] b_ctl_rd_d_in,
  input  logic        b_ctl_rd_empty_in,
  output logic        b_data_rd_en_out,
  input  logic [63:0] b_data_rd_d_in,
  input  logic        b_data_rd_empty_in,
  output logic        ctl_wr_en_out,
  output logic [15:0] ctl_wr_d_out,
  input  logic        ctl_wr_full_in,
  output logic        data_wr_en_out,
  output logic [63:0] data_wr_d_out,
  input  logic        data_wr_full_in,
  output logic        grant_out,
  output logic        busy_out,
  output logic        err_out
);

  localparam int DATA_W = 64;
  localparam int CTL_W  = 16;
  localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_COPY,
    S_CTL_WR,
    S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [CTL_W-1:0]    ctl_lat_q, ctl_lat_d;
  logic                data_wr_en_q, data_wr_en_d;
  logic [DATA_W-1:0]   data_wr_d_q, data_wr_d_d;
  logic                ctl_wr_en_q, ctl_wr_en_d;
  logic [CTL_W-1:0]    ctl_wr_d_q, ctl_wr_d_d;

  logic [CTL_W-1:0]    src_ctl;
  logic                src_ctl_empty;
  logic [DATA_W-1:0]   src_data;
  logic                src_data_empty;
  logic [LEN_W-1:0]    hdr_len;
  logic                ctl_pop, data_pop;

  // grant_q names the source currently being served outside IDLE
  always_comb begin
    src_ctl        = a_ctl_rd_d_in;
    src_ctl_empty  = a_ctl_rd_empty_in;
    src_data       = a_data_rd_d_in;
    src_data_empty = a_data_rd_empty_in;
    if (grant_q) begin
      src_ctl        = b_ctl_rd_d_in;
      src_ctl_empty  = b_ctl_rd_empty_in;
      src_data       = b_data_rd_d_in;
      src_data_empty = b_data_rd_empty_in;
    end
  end

  assign hdr_len = src_ctl[LEN_W-1:0];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    busy_d       = busy_q;
    err_d        = err_q;
    rem_d        = rem_q;
    ctl_lat_d    = ctl_lat_q;
    data_wr_en_d = 1'b0;
    data_wr_d_d  = data_wr_d_q;
    ctl_wr_en_d  = 1'b0;
    ctl_wr_d_d   = ctl_wr_d_q;
    ctl_pop      = 1'b0;
    data_pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!a_ctl_rd_empty_in && !b_ctl_rd_empty_in) begin
          grant_d = ~grant_q;
          busy_d  = 1'b1;
          state_d = S_HDR;
        end else if (!a_ctl_rd_empty_in) begin
          grant_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_HDR;
        end else if (!b_ctl_rd_empty_in) begin
          grant_d = 1'b1;
          busy_d  = 1'b1;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        ctl_pop   = !src_ctl_empty;
        ctl_lat_d = src_ctl;
        rem_d     = hdr_len;
        if (hdr_len == '0 || {1'b0, hdr_len} > MAX_LEN) begin
          err_d   = 1'b1;
          state_d = S_DRAIN;
        end else begin
          state_d = S_COPY;
        end
      end
      S_COPY: begin
        data_pop = !src_data_empty && !data_wr_full_in && rem_q != '0;
        if (data_pop) begin
          data_wr_en_d = 1'b1;
          data_wr_d_d  = src_data;
          rem_d        = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = S_CTL_WR;
        end
      end
      S_CTL_WR: begin
        // Entered together with the last data write, so ctl always trails data
        if (!ctl_wr_full_in) begin
          ctl_wr_en_d = 1'b1;
          ctl_wr_d_d  = ctl_lat_q;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_DRAIN: begin
        data_pop = !src_data_empty && rem_q != '0;
        if (data_pop) rem_d = rem_q - LEN_W'(1);
        if (!data_pop || rem_q == LEN_W'(1)) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign a_ctl_rd_en_out  = ctl_pop  && !grant_q;
  assign b_ctl_rd_en_out  = ctl_pop  &&  grant_q;
  assign a_data_rd_en_out = data_pop && !grant_q;
  assign b_data_rd_en_out = data_pop &&  grant_q;

  // Register stage: control and shared-FIFO write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b1;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      rem_q        <= '0;
      data_wr_en_q <= 1'b0;
      data_wr_d_q  <= '0;
      ctl_wr_en_q  <= 1'b0;
      ctl_wr_d_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      rem_q        <= rem_d;
      data_wr_en_q <= data_wr_en_d;
      data_wr_d_q  <= data_wr_d_d;
      ctl_wr_en_q  <= ctl_wr_en_d;
      ctl_wr_d_q   <= ctl_wr_d_d;
    end
  end

  always_ff @(posedge clk) begin
    ctl_lat_q <= ctl_lat_d;
  end

  assign ctl_wr_en_out  = ctl_wr_en_q;
  assign ctl_wr_d_out   = ctl_wr_d_q;
  assign data_wr_en_out = data_wr_en_q;
  assign data_wr_d_out  = data_wr_d_q;
  assign grant_out      = grant_q;
  assign busy_out       = busy_q;
  assign err_out        = err_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: queue-based FWFT source models, a shared-FIFO sink
// log, a table of frame scenarios, and hand-written multi-cycle sequences.
module tb_eth_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_ctl_rd_en_out, a_data_rd_en_out, b_ctl_rd_en_out, b_data_rd_en_out;
  logic [15:0] a_ctl_rd_d_in, b_ctl_rd_d_in;
  logic [63:0] a_data_rd_d_in, b_data_rd_d_in;
  logic        a_ctl_rd_empty_in, a_data_rd_empty_in, b_ctl_rd_empty_in, b_data_rd_empty_in;
  logic        ctl_wr_en_out, data_wr_en_out;
  logic [15:0] ctl_wr_d_out;
  logic [63:0] data_wr_d_out;
  logic        ctl_wr_full_in = 1'b0;
  logic        data_wr_full_in = 1'b0;
  logic        grant_out, busy_out, err_out;

  always #5 clk = ~clk;

  eth_tx_arbiter #(.LEN_W(7), .MAX_WORDS(64)) dut (
    .clk(clk), .rst(rst),
    .a_ctl_rd_en_out(a_ctl_rd_en_out), .a_ctl_rd_d_in(a_ctl_rd_d_in),
    .a_ctl_rd_empty_in(a_ctl_rd_empty_in),
    .a_data_rd_en_out(a_data_rd_en_out), .a_data_rd_d_in(a_data_rd_d_in),
    .a_data_rd_empty_in(a_data_rd_empty_in),
    .b_ctl_rd_en_out(b_ctl_rd_en_out), .b_ctl_rd_d_in(b_ctl_rd_d_in),
    .b_ctl_rd_empty_in(b_ctl_rd_empty_in),
    .b_data_rd_en_out(b_data_rd_en_out), .b_data_rd_d_in(b_data_rd_d_in),
    .b_data_rd_empty_in(b_data_rd_empty_in),
    .ctl_wr_en_out(ctl_wr_en_out), .ctl_wr_d_out(ctl_wr_d_out), .ctl_wr_full_in(ctl_wr_full_in),
    .data_wr_en_out(data_wr_en_out), .data_wr_d_out(data_wr_d_out), .data_wr_full_in(data_wr_full_in),
    .grant_out(grant_out), .busy_out(busy_out), .err_out(err_out)
  );

  logic [15:0] a_cq[$], b_cq[$], out_c[$], exp_c[$];
  logic [63:0] a_dq[$], b_dq[$], out_d[$], exp_d[$];
  int          out_dc[$], out_cc[$], ctl_at[$], exp_cat[$];
  int          total = 0, bad = 0, cyc = 0, full_per = 0, viol = 0;
  bit          prev_dfull = 1'b0, prev_cfull = 1'b0;

  typedef struct {
    logic [15:0] a_ctl; int a_fr; int a_w;
    logic [15:0] b_ctl; int b_fr; int b_w;
    int fper; logic e_err; logic e_grant; bit timing;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s id=%0d: got %0h, want %0h", nm, id, act, req);
    end
  endtask

  function automatic logic [63:0] wv(input bit src, input int f, input int w);
    return {(src ? 8'hBB : 8'hAA), 8'(f), 16'h5A5A, 32'(w)};
  endfunction

  task automatic refresh();
    a_ctl_rd_empty_in  = (a_cq.size() == 0);
    b_ctl_rd_empty_in  = (b_cq.size() == 0);
    a_data_rd_empty_in = (a_dq.size() == 0);
    b_data_rd_empty_in = (b_dq.size() == 0);
    a_ctl_rd_d_in = 16'h0; b_ctl_rd_d_in = 16'h0; a_data_rd_d_in = 64'h0; b_data_rd_d_in = 64'h0;
    if (a_cq.size() != 0) a_ctl_rd_d_in  = a_cq[0];
    if (b_cq.size() != 0) b_ctl_rd_d_in  = b_cq[0];
    if (a_dq.size() != 0) a_data_rd_d_in = a_dq[0];
    if (b_dq.size() != 0) b_data_rd_d_in = b_dq[0];
  endtask

  // Entered and left at a falling edge; pops are applied just after the rising edge.
  task automatic step();
    bit pac, pad, pbc, pbd;
    logic [63:0] junk_d;
    logic [15:0] junk_c;
    if (full_per > 0) begin
      data_wr_full_in = ((cyc / full_per) % 2) == 1;
      ctl_wr_full_in  = ((cyc / full_per) % 2) == 1;
    end else begin
      data_wr_full_in = 1'b0;
      ctl_wr_full_in  = 1'b0;
    end
    #1;
    if (ctl_wr_en_out === 1'b1) begin
      if (prev_cfull) viol++;
      out_c.push_back(ctl_wr_d_out); out_cc.push_back(cyc); ctl_at.push_back(out_d.size());
    end
    if (data_wr_en_out === 1'b1) begin
      if (prev_dfull) viol++;
      out_d.push_back(data_wr_d_out); out_dc.push_back(cyc);
    end
    pac = (a_ctl_rd_en_out === 1'b1);  pad = (a_data_rd_en_out === 1'b1);
    pbc = (b_ctl_rd_en_out === 1'b1);  pbd = (b_data_rd_en_out === 1'b1);
    if ((pac && a_ctl_rd_empty_in) || (pad && a_data_rd_empty_in) ||
        (pbc && b_ctl_rd_empty_in) || (pbd && b_data_rd_empty_in)) viol++;
    prev_dfull = data_wr_full_in;
    prev_cfull = ctl_wr_full_in;
    @(posedge clk);
    #1;
    if (pac && a_cq.size() != 0) junk_c = a_cq.pop_front();
    if (pbc && b_cq.size() != 0) junk_c = b_cq.pop_front();
    if (pad && a_dq.size() != 0) junk_d = a_dq.pop_front();
    if (pbd && b_dq.size() != 0) junk_d = b_dq.pop_front();
    refresh();
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_cq.delete(); b_cq.delete(); a_dq.delete(); b_dq.delete();
    out_c.delete(); out_d.delete(); out_dc.delete(); out_cc.delete(); ctl_at.delete();
    exp_c.delete(); exp_d.delete(); exp_cat.delete();
    viol = 0; prev_dfull = 1'b0; prev_cfull = 1'b0;
    refresh();
  endtask

  task automatic check_reset_state(input int id);
    #1;
    chk("rst_data_wr_en", id, 64'(data_wr_en_out), 64'd0);
    chk("rst_ctl_wr_en", id, 64'(ctl_wr_en_out), 64'd0);
    chk("rst_data_wr_d", id, data_wr_d_out, 64'd0);
    chk("rst_ctl_wr_d", id, 64'(ctl_wr_d_out), 64'd0);
    chk("rst_grant", id, 64'(grant_out), 64'd1);
    chk("rst_busy", id, 64'(busy_out), 64'd0);
    chk("rst_err", id, 64'(err_out), 64'd0);
    chk("rst_rd_en", id, 64'({a_ctl_rd_en_out, a_data_rd_en_out, b_ctl_rd_en_out, b_data_rd_en_out}), 64'd0);
  endtask

  // Loads one frame into a source; only legal frames are expected at the output.
  task automatic add_frame(input bit src, input logic [15:0] ctl, input int nw, input int f);
    logic [6:0] len;
    bit legal;
    len = ctl[6:0];
    legal = (len != 7'd0) && (len <= 7'd64);
    for (int w = 0; w < nw; w++) begin
      if (src) b_dq.push_back(wv(src, f, w)); else a_dq.push_back(wv(src, f, w));
      if (legal) exp_d.push_back(wv(src, f, w));
    end
    if (src) b_cq.push_back(ctl); else a_cq.push_back(ctl);
    if (legal) begin
      exp_c.push_back(ctl);
      exp_cat.push_back(exp_d.size());
    end
  endtask

  task automatic run_until(input int id, input int budget);
    int k;
    k = 0;
    while ((out_d.size() < exp_d.size() || out_c.size() < exp_c.size() || busy_out !== 1'b0 ||
            (a_cq.size() + b_cq.size() + a_dq.size() + b_dq.size()) != 0) && k < budget) begin
      step();
      k++;
    end
    total++;
    if (k >= budget) begin
      bad++;
      $display("FAIL timeout id=%0d: traffic still pending after %0d cycles", id, k);
    end
    repeat (4) step();
  endtask

  task automatic compare_outputs(input int id);
    chk("data_count", id, 64'(out_d.size()), 64'(exp_d.size()));
    foreach (exp_d[i]) if (i < out_d.size()) chk("data_word", id, out_d[i], exp_d[i]);
    chk("ctl_count", id, 64'(out_c.size()), 64'(exp_c.size()));
    foreach (exp_c[i]) begin
      if (i < out_c.size()) begin
        chk("ctl_word", id, 64'(out_c[i]), 64'(exp_c[i]));
        chk("ctl_after_data", id, 64'(ctl_at[i]), 64'(exp_cat[i]));
      end
    end
    chk("protocol_violations", id, 64'(viol), 64'd0);
    chk("sources_drained", id, 64'(a_cq.size() + b_cq.size() + a_dq.size() + b_dq.size()), 64'd0);
    chk("busy_idle", id, 64'(busy_out), 64'd0);
  endtask

  initial begin
    int k;
    vecs[0] = '{16'h0008, 1, 8,  16'h0000, 0, 0, 0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{16'h0008, 3, 8,  16'h0008, 3, 8, 0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h000A, 1, 10, 16'h0000, 0, 0, 3, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h0000, 0, 0,  16'h0005, 1, 5, 0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h0040, 1, 64, 16'h0008, 1, 8, 0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'hC041, 1, 65, 16'h0000, 0, 0, 0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'h8305, 2, 5,  16'h0003, 2, 3, 2, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{16'h007F, 1, 3,  16'h0000, 0, 0, 0, 1'b1, 1'b0, 1'b0};
    refresh();
    @(negedge clk);
    do_reset();
    check_reset_state(200);

    for (int v = 0; v < 8; v++) begin
      do_reset();
      full_per = vecs[v].fper;
      for (int f = 0; f < 3; f++) begin
        if (f < vecs[v].a_fr) add_frame(1'b0, vecs[v].a_ctl, vecs[v].a_w, f);
        if (f < vecs[v].b_fr) add_frame(1'b1, vecs[v].b_ctl, vecs[v].b_w, f);
      end
      refresh();
      run_until(v, 3000);
      compare_outputs(v);
      chk("err", v, 64'(err_out), 64'(vecs[v].e_err));
      chk("grant", v, 64'(grant_out), 64'(vecs[v].e_grant));
      if (vecs[v].timing && out_dc.size() >= 8 && out_cc.size() >= 1) begin
        for (int i = 1; i < 8; i++) chk("data_back_to_back", v, 64'(out_dc[i] - out_dc[i-1]), 64'd1);
        chk("ctl_one_after_last", v, 64'(out_cc[0] - out_dc[7]), 64'd1);
      end
      full_per = 0;
    end

    // Source A underruns mid-frame while B waits
    do_reset();
    for (int w = 0; w < 4; w++) a_dq.push_back(wv(1'b0, 0, w));
    a_cq.push_back(16'h0009);
    for (int w = 0; w < 8; w++) b_dq.push_back(wv(1'b1, 0, w));
    b_cq.push_back(16'h0008);
    refresh();
    repeat (20) step();
    #1;
    chk("underrun_busy", 100, 64'(busy_out), 64'd1);
    chk("underrun_grant", 100, 64'(grant_out), 64'd0);
    chk("underrun_words", 100, 64'(out_d.size()), 64'd4);
    chk("underrun_b_waits", 100, 64'(b_cq.size()), 64'd1);
    chk("underrun_no_write", 100, 64'(data_wr_en_out), 64'd0);
    for (int w = 4; w < 9; w++) a_dq.push_back(wv(1'b0, 0, w));
    for (int w = 0; w < 9; w++) exp_d.push_back(wv(1'b0, 0, w));
    exp_c.push_back(16'h0009); exp_cat.push_back(9);
    for (int w = 0; w < 8; w++) exp_d.push_back(wv(1'b1, 0, w));
    exp_c.push_back(16'h0008); exp_cat.push_back(17);
    refresh();
    run_until(100, 2000);
    compare_outputs(100);

    // Zero-length frame then a legal one; err must stay set
    do_reset();
    a_cq.push_back(16'h0000);
    add_frame(1'b0, 16'h0008, 8, 1);
    refresh();
    run_until(101, 2000);
    compare_outputs(101);
    chk("err_sticky", 101, 64'(err_out), 64'd1);

    // Reset after the third word of an 8-word frame
    do_reset();
    add_frame(1'b0, 16'h0008, 8, 0);
    refresh();
    k = 0;
    while (out_d.size() < 3 && k < 100) begin step(); k++; end
    chk("midreset_progress", 102, 64'(out_d.size()), 64'd3);
    do_reset();
    check_reset_state(102);
    add_frame(1'b0, 16'h0008, 8, 1);
    add_frame(1'b1, 16'h0004, 4, 1);
    refresh();
    k = 0;
    while (busy_out !== 1'b1 && k < 20) begin step(); k++; end
    chk("midreset_first_grant", 102, 64'(grant_out), 64'd0);
    run_until(102, 2000);
    compare_outputs(102);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
Shares the single transmit FIFO pair (16-bit ctl FIFO, 64-bit data FIFO) feeding the Ethernet MAC between two frame encoders, A and B. Each encoder owns a private ctl/data FIFO pair with identical framing: N data words first, then one ctl word whose low bits hold N.
The arbiter moves whole frames, never interleaved, from the winning source into the shared FIFOs. Sources are served round-robin.
It sits between the encoders (e.g. eth_encode on port A, a future status encoder on port B) and the MAC transmitter.

Parameters:
LEN_W, 7, width of the word-count field in ctl word bits [LEN_W-1:0]
MAX_WORDS, 64, largest legal frame length in 64-bit words

Ports:
clk  in  1  system clock
rst  in  1  reset
a_ctl_rd_en_out  out  1  pop source A ctl FIFO
a_ctl_rd_d_in  in  16  source A ctl word (first-word-fall-through)
a_ctl_rd_empty_in  in  1  source A ctl FIFO empty
a_data_rd_en_out  out  1  pop source A data FIFO
a_data_rd_d_in  in  64  source A data word (FWFT)
a_data_rd_empty_in  in  1  source A data FIFO empty
b_*  (same six ports for source B)
ctl_wr_en_out  out  1  write shared ctl FIFO
ctl_wr_d_out  out  16  ctl word written
ctl_wr_full_in  in  1  shared ctl FIFO full
data_wr_en_out  out  1  write shared data FIFO
data_wr_d_out  out  64  data word written
data_wr_full_in  in  1  shared data FIFO full
grant_out  out  1  source of current/last frame (0=A, 1=B)
busy_out  out  1  frame transfer in progress
err_out  out  1  sticky: illegal length seen

Behaviour:
- Reset: one clock; rst is synchronous, active-high. On rst: state IDLE, all *_wr_en_out 0, ctl_wr_d_out 0, data_wr_d_out 0, grant_out 1 (so A wins first), busy_out 0, err_out 0, remaining count 0.
- Input FIFOs are FWFT. A word is valid whenever empty=0 and is consumed at the rising edge where rd_en=1.
- rd_en outputs are combinational from the current state and flags. They are never asserted while the matching empty=1.
- Shared FIFO full flags assert with at least 2 free entries. A write is issued in the cycle after full was sampled low.
- IDLE:
  - Pending sources are those with ctl_empty=0.
  - If both are pending, grant the one not equal to grant_out. If one is pending, grant it.
  - On grant, update grant_out, set busy_out=1, go to HDR. Otherwise stay in IDLE.
  - All wr_en are 0 in IDLE.
- HDR (1 cycle):
  - Latch ctl word and remaining = ctl[LEN_W-1:0] (zero-extended).
  - Pop ctl: ctl_rd_en=1 for exactly this cycle; data is guaranteed valid because empty was 0 on entry.
  - If length is 0 or greater than MAX_WORDS: set err_out=1, go to DRAIN.
  - Otherwise go to COPY.
- COPY:
  - data_rd_en (granted source) = data_empty=0 AND data_wr_full_in=0 AND remaining≠0.
  - When popped: next cycle data_wr_en_out=1, data_wr_d_out = popped word (1-cycle latency, 1 word/cycle sustained), and remaining decrements.
  - Otherwise data_wr_en_out=0 next cycle.
  - When remaining reaches 0 (after the final pop), go to CTL_WR. The final data write lands in the same cycle CTL_WR is entered.
- CTL_WR:
  - data_wr_en_out is 0 from the cycle after the final write.
  - When ctl_wr_full_in=0: ctl_wr_en_out=1 for one cycle, ctl_wr_d_out = latched ctl word unchanged. Go to IDLE and drop busy_out.
  - While full: hold ctl_wr_en_out=0 and wait.
  - Ctl is always written strictly after the frame's last data write, so the MAC never sees a ctl word before its data.
- DRAIN (illegal length):
  - Pop and discard min(len, available) data words. A length-0 frame pops nothing.
  - Nothing is written to the shared FIFOs. Go to IDLE when done.
  - The discarded frame's ctl is not forwarded.
- Source empty mid-frame: COPY stalls with no writes and no timeout. No other source is granted until the frame completes.
- Shared full mid-frame: rd_en stops immediately. The word already in flight is still written, which is covered by the 2-entry slack.
- Reset mid-frame: return to reset state immediately. Partial frames in the FIFOs are the system's concern, since the FIFOs share rst.
- Both sources are ungranted on the same cycle a new ctl arrives: arbitration is sampled only in IDLE.

Test Plan:
- Single A frame: A holds ctl 16'h0008 and 8 data words D0..D7, B empty → D0..D7 on consecutive cycles; ctl_wr_d_out=16'h0008 exactly one cycle after D7; grant_out=0; A rd_en pulses match words popped.
- Round-robin: A and B each preloaded with 3 frames of length 8 → shared output order A,B,A,B,A,B; no frames interleaved; 48 data writes and 6 ctl writes total.
- Backpressure: toggle data_wr_full_in every 3 cycles during a length-10 frame → all 10 words written in order, none duplicated or lost; ctl written last.
- Source underrun: A ctl 16'h0009 with only 4 data words, the rest supplied 20 cycles later → COPY stalls, B stays ungranted, frame completes intact.
- Illegal length: A ctl 16'h0000, then a valid frame of length 8 → err_out=1 and sticky; no shared writes for the first frame; second frame forwarded normally.
- Mid-frame reset: assert rst for 1 cycle after word 3 of 8 → all outputs at reset values the next cycle; grant_out=1; next grant goes to A.
